// File: rtl/uart_pkg.sv
// Shared UART definitions: frame sizes, register indices and the RX buffer entry layout.
package uart_pkg;

  localparam int unsigned MAX_FRAME_SIZE = 11;
  localparam int unsigned MIN_FRAME_SIZE = 8;

  localparam int unsigned REG_IDX_W = 2;
  localparam logic [REG_IDX_W-1:0] SR   = 2'd0;
  localparam logic [REG_IDX_W-1:0] CR   = 2'd1;
  localparam logic [REG_IDX_W-1:0] RXDR = 2'd2;
  localparam logic [REG_IDX_W-1:0] TXDR = 2'd3;

  typedef struct packed {
    logic                      parity_err;
    logic [MAX_FRAME_SIZE-1:0] frame;
  } rx_entry_t;

  // True when v is a non-zero power of two.
  function automatic bit is_pow2(input int unsigned v);
    return (v != 0) && ((v & (v - 1)) == 0);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Register-array storage for the RX FIFO: synchronous write, asynchronous read, no reset.
module fifo_mem #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned WIDTH = 12
) (
  input  logic                     clk_i,
  input  logic                     we_i,
  input  logic [$clog2(DEPTH)-1:0] waddr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic [$clog2(DEPTH)-1:0] raddr_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      r_mem[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = r_mem[raddr_i];

endmodule

// File: rtl/uart_rx_fifo.sv
// RX frame buffer between the UART receive frontend and the register block.
// First-word-fall-through head, occupancy/threshold flags and sticky overflow.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned WIDTH     = MAX_FRAME_SIZE,
  parameter int unsigned THRESHOLD = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   flush_i,
  input  logic [WIDTH-1:0]       frame_i,
  input  logic                   parity_err_i,
  input  logic                   valid_i,
  input  logic                   pop_i,
  input  logic                   clear_ovf_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   parity_err_o,
  output logic                   empty_o,
  output logic                   full_o,
  output logic [$clog2(DEPTH):0] count_o,
  output logic                   threshold_o,
  output logic                   overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam int unsigned EW = WIDTH + 1;
  localparam bit PARAMS_OK = is_pow2(DEPTH) && (DEPTH >= 2) &&
                             (THRESHOLD >= 1) && (THRESHOLD <= DEPTH);

  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [PW-1:0] r_count;
  logic          r_ovf;

  logic          w_empty;
  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_evt;
  logic [EW-1:0] w_wdata;
  logic [EW-1:0] w_rdata;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == PW'(DEPTH));

  // Flush overrides everything; a full FIFO still accepts a frame when the head is popped.
  always_comb begin
    w_push    = 1'b0;
    w_pop     = 1'b0;
    w_ovf_evt = 1'b0;
    if (!flush_i) begin
      w_pop     = pop_i && !w_empty;
      w_push    = valid_i && (!w_full || pop_i);
      w_ovf_evt = valid_i && w_full && !pop_i;
    end
  end

  assign w_wdata = {parity_err_i, frame_i};

  fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_mem (
    .clk_i   (clk_i),
    .we_i    (w_push),
    .waddr_i (r_wptr[AW-1:0]),
    .wdata_i (w_wdata),
    .raddr_i (r_rptr[AW-1:0]),
    .rdata_o (w_rdata)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush_i) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + PW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + PW'(1);
        2'b01:   r_count <= r_count - PW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // A new overflow wins over a same-cycle clear request.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ovf <= 1'b0;
    end else if (flush_i) begin
      r_ovf <= 1'b0;
    end else if (w_ovf_evt) begin
      r_ovf <= 1'b1;
    end else if (clear_ovf_i) begin
      r_ovf <= 1'b0;
    end
  end

  assign data_o       = w_empty ? '0 : w_rdata[WIDTH-1:0];
  assign parity_err_o = w_empty ? 1'b0 : w_rdata[WIDTH];
  assign empty_o      = w_empty;
  assign full_o       = w_full;
  assign count_o      = r_count;
  assign threshold_o  = (r_count >= PW'(THRESHOLD));
  assign overflow_o   = r_ovf;

  a_params_ok: assert property (@(posedge clk_i) PARAMS_OK)
    else $error("uart_rx_fifo: DEPTH must be a power of two >= 2 and 1 <= THRESHOLD <= DEPTH");

  a_count_matches_ptrs: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_count == PW'(r_wptr - r_rptr))
    else $error("uart_rx_fifo: count out of step with pointers");

  a_count_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    r_count <= PW'(DEPTH))
    else $error("uart_rx_fifo: count exceeds DEPTH");

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
module tb_uart_rx_fifo;

  localparam int unsigned DEPTH     = 8;
  localparam int unsigned WIDTH     = 11;
  localparam int unsigned THRESHOLD = 4;
  localparam int unsigned CW        = $clog2(DEPTH) + 1;
  localparam int unsigned VW        = WIDTH + 5 + CW;

  logic             clk = 1'b0;
  logic             rst_ni = 1'b0;
  logic             flush_i = 1'b0;
  logic [WIDTH-1:0] frame_i = '0;
  logic             parity_err_i = 1'b0;
  logic             valid_i = 1'b0;
  logic             pop_i = 1'b0;
  logic             clear_ovf_i = 1'b0;
  logic [WIDTH-1:0] data_o;
  logic             parity_err_o;
  logic             empty_o;
  logic             full_o;
  logic [CW-1:0]    count_o;
  logic             threshold_o;
  logic             overflow_o;

  uart_rx_fifo #(
    .DEPTH     (DEPTH),
    .WIDTH     (WIDTH),
    .THRESHOLD (THRESHOLD)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .flush_i      (flush_i),
    .frame_i      (frame_i),
    .parity_err_i (parity_err_i),
    .valid_i      (valid_i),
    .pop_i        (pop_i),
    .clear_ovf_i  (clear_ovf_i),
    .data_o       (data_o),
    .parity_err_o (parity_err_o),
    .empty_o      (empty_o),
    .full_o       (full_o),
    .count_o      (count_o),
    .threshold_o  (threshold_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk = ~clk;

  logic [WIDTH:0] m_q[$];
  bit             m_ovf = 1'b0;
  int             n_checks = 0;
  int             n_pass = 0;

  // One clock of stimulus; the model applies the buffer rules to the queue at the same edge.
  task automatic drive(input bit v, input logic [WIDTH-1:0] f, input bit p,
                       input bit pp, input bit clr, input bit fl);
    bit was_full;
    valid_i = v; frame_i = f; parity_err_i = p;
    pop_i = pp; clear_ovf_i = clr; flush_i = fl;
    @(posedge clk);
    if (fl) begin
      m_q.delete();
      m_ovf = 1'b0;
    end else begin
      was_full = (m_q.size() == DEPTH);
      if (v && was_full && !pp) m_ovf = 1'b1;
      else if (clr)             m_ovf = 1'b0;
      if (pp && m_q.size() > 0) void'(m_q.pop_front());
      if (v && (!was_full || pp)) m_q.push_back({p, f});
    end
    #1;
    valid_i = 1'b0; frame_i = '0; parity_err_i = 1'b0;
    pop_i = 1'b0; clear_ovf_i = 1'b0; flush_i = 1'b0;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    int n;
    logic [WIDTH:0] h;
    n = m_q.size();
    h = (n > 0) ? m_q[0] : '0;
    return {h[WIDTH-1:0], h[WIDTH], (n == 0), (n == DEPTH), CW'(n),
            (n >= THRESHOLD), m_ovf};
  endfunction

  function automatic logic [VW-1:0] obs_vec();
    return {data_o, parity_err_o, empty_o, full_o, count_o, threshold_o, overflow_o};
  endfunction

  task automatic test_reset();
    #2;
    n_checks++;
    if ({empty_o, count_o, data_o, overflow_o} !== {1'b1, CW'(0), WIDTH'(0), 1'b0})
      $display("FAIL reset_initial: got empty=%b count=%0d data=%h ovf=%b want 1/0/000/0",
               empty_o, count_o, data_o, overflow_o);
    else n_pass++;
    @(negedge clk) rst_ni = 1'b1;
    @(posedge clk); #1;
    drive(1'b1, 11'h2A5, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 11'h13C, 1'b0, 1'b0, 1'b0, 1'b0);
    #3 rst_ni = 1'b0;
    m_q.delete(); m_ovf = 1'b0;
    #1;
    n_checks++;
    if (empty_o !== 1'b1) $display("FAIL reset_empty: got %b want 1", empty_o);
    else n_pass++;
    n_checks++;
    if (count_o !== CW'(0)) $display("FAIL reset_count: got %0d want 0", count_o);
    else n_pass++;
    n_checks++;
    if ({data_o, parity_err_o, full_o, threshold_o, overflow_o} !== '0)
      $display("FAIL reset_outputs: got data=%h perr=%b full=%b thr=%b ovf=%b want zeros",
               data_o, parity_err_o, full_o, threshold_o, overflow_o);
    else n_pass++;
    @(negedge clk) rst_ni = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single();
    drive(1'b1, 11'h155, 1'b1, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({data_o, parity_err_o, count_o} !== {11'h155, 1'b1, CW'(1)})
      $display("FAIL single_push: got data=%h perr=%b count=%0d want 155/1/1",
               data_o, parity_err_o, count_o);
    else n_pass++;
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({empty_o, data_o, parity_err_o} !== {1'b1, WIDTH'(0), 1'b0})
      $display("FAIL single_pop: got empty=%b data=%h perr=%b want 1/000/0",
               empty_o, data_o, parity_err_o);
    else n_pass++;
  endtask

  task automatic test_fill_overflow();
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, WIDTH'(i), 1'b0, 1'b0, 1'b0, 1'b0);
      n_checks++;
      if ({count_o, threshold_o} !== {CW'(i), (i >= 4)})
        $display("FAIL fill_count_thr: got count=%0d thr=%b want %0d/%b",
                 count_o, threshold_o, i, (i >= 4));
      else n_pass++;
    end
    drive(1'b1, 11'h009, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({full_o, overflow_o, count_o} !== {1'b1, 1'b1, CW'(8)})
      $display("FAIL overflow_flags: got full=%b ovf=%b count=%0d want 1/1/8",
               full_o, overflow_o, count_o);
    else n_pass++;
    for (int i = 1; i <= 8; i++) begin
      n_checks++;
      if (data_o !== WIDTH'(i)) $display("FAIL overflow_order: got %h want %h", data_o, WIDTH'(i));
      else n_pass++;
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    n_checks++;
    if ({empty_o, data_o} !== {1'b1, WIDTH'(0)})
      $display("FAIL overflow_drained: got empty=%b data=%h want 1/000", empty_o, data_o);
    else n_pass++;
  endtask

  task automatic test_simultaneous();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (overflow_o !== 1'b0) $display("FAIL clear_ovf: got %b want 0", overflow_o);
    else n_pass++;
    for (int i = 0; i < 8; i++) drive(1'b1, WIDTH'(16 + i), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 11'h020, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({count_o, overflow_o, data_o} !== {CW'(8), 1'b0, 11'h011})
      $display("FAIL full_push_pop: got count=%0d ovf=%b data=%h want 8/0/011",
               count_o, overflow_o, data_o);
    else n_pass++;
    repeat (7) drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({data_o, count_o} !== {11'h020, CW'(1)})
      $display("FAIL full_push_pop_tail: got data=%h count=%0d want 020/1", data_o, count_o);
    else n_pass++;
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 11'h030, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({count_o, data_o} !== {CW'(1), 11'h030})
      $display("FAIL empty_push_pop: got count=%0d data=%h want 1/030", count_o, data_o);
    else n_pass++;
    drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_wrap_threshold();
    logic [VW-1:0] e;
    for (int i = 0; i < 3; i++)
      drive(1'b1, WIDTH'($urandom), 1'($urandom), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) begin
      drive(1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom),
            1'($urandom_range(0, 1)), 1'b0, 1'b0);
      e = exp_vec();
      n_checks++;
      if (obs_vec() !== e) $display("FAIL wrap_status cyc%0d: got %h want %h", i, obs_vec(), e);
      else n_pass++;
    end
    while (m_q.size() < DEPTH) drive(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, WIDTH'($urandom), 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if (overflow_o !== 1'b1) $display("FAIL ovf_set_beats_clear: got %b want 1", overflow_o);
    else n_pass++;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1, 1'b0);
    n_checks++;
    if ({overflow_o, count_o} !== {1'b0, CW'(8)})
      $display("FAIL ovf_clear: got ovf=%b count=%0d want 0/8", overflow_o, count_o);
    else n_pass++;
  endtask

  task automatic test_flush();
    drive(1'b1, 11'h3FF, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if ({count_o, overflow_o} !== {CW'(5), 1'b1})
      $display("FAIL flush_setup: got count=%0d ovf=%b want 5/1", count_o, overflow_o);
    else n_pass++;
    drive(1'b1, 11'h7AA, 1'b1, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({count_o, empty_o, overflow_o, data_o} !== {CW'(0), 1'b1, 1'b0, WIDTH'(0)})
      $display("FAIL flush_clear: got count=%0d empty=%b ovf=%b data=%h want 0/1/0/000",
               count_o, empty_o, overflow_o, data_o);
    else n_pass++;
    drive(1'b1, 11'h055, 1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({data_o, parity_err_o, count_o} !== {11'h055, 1'b0, CW'(1)})
      $display("FAIL flush_after: got data=%h perr=%b count=%0d want 055/0/1",
               data_o, parity_err_o, count_o);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [VW-1:0] e;
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 9) < 6), WIDTH'($urandom), 1'($urandom),
            ($urandom_range(0, 9) < 5), ($urandom_range(0, 19) == 0),
            ($urandom_range(0, 39) == 0));
      e = exp_vec();
      n_checks++;
      if (obs_vec() !== e) $display("FAIL random_status cyc%0d: got %h want %h", i, obs_vec(), e);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] vals [DEPTH];
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      vals[i] = WIDTH'($urandom);
      drive(1'b1, vals[i], 1'b0, 1'b0, 1'b0, 1'b0);
    end
    n_checks++;
    if ({full_o, count_o} !== {1'b1, CW'(DEPTH)})
      $display("FAIL b2b_fill: got full=%b count=%0d want 1/%0d", full_o, count_o, DEPTH);
    else n_pass++;
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (data_o !== vals[i]) $display("FAIL b2b_drain %0d: got %h want %h", i, data_o, vals[i]);
      else n_pass++;
      drive(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    n_checks++;
    if (empty_o !== 1'b1) $display("FAIL b2b_empty: got %b want 1", empty_o);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_overflow();
    test_simultaneous();
    test_wrap_threshold();
    test_flush();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

- Receive buffer between the RX frontend and the register block of the Wishbone UART.
- Captures each validated frame from the frontend together with its parity status, and holds up to DEPTH frames in arrival order.
- Presents the oldest frame to the register block in first-word-fall-through form, so a read of RXDR followed by a pop drains it.
- Reports occupancy, threshold and sticky overflow status for the status register.

## Interface
Parameters:
- DEPTH, 8, number of frame entries; power of two, ≥ 2
- WIDTH, 11, frame width in bits (maximum UART frame size)
- THRESHOLD, 4, occupancy at or above which threshold_o is asserted; 1..DEPTH

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- flush_i  in  1  synchronous clear of all entries (driven on CR write)
- frame_i  in  WIDTH  received frame from the RX frontend
- parity_err_i  in  1  parity error flag accompanying frame_i
- valid_i  in  1  single-cycle strobe: frame_i and parity_err_i are valid
- pop_i  in  1  discard the head entry (RXDR read)
- clear_ovf_i  in  1  clear the sticky overflow flag
- data_o  out  WIDTH  head frame; 0 when empty
- parity_err_o  out  1  parity flag of the head entry; 0 when empty
- empty_o  out  1  no entries
- full_o  out  1  DEPTH entries
- count_o  out  $clog2(DEPTH)+1  number of entries, 0..DEPTH
- threshold_o  out  1  count_o ≥ THRESHOLD
- overflow_o  out  1  sticky: a frame was dropped because the FIFO was full

## Operation
- Storage is an array of DEPTH entries of {parity_err, frame}.
- Read and write pointers are each $clog2(DEPTH)+1 bits:
  - the low bits index the array;
  - the MSB disambiguates full from empty;
  - pointers wrap naturally modulo 2·DEPTH.
- Push occurs when valid_i=1 and (full_o=0 or pop_i=1). The entry is written at the write pointer, which then increments.
- Pop occurs when pop_i=1 and empty_o=0; the read pointer increments. A pop while empty is ignored and has no side effects.
- Simultaneous push and pop:
  - when full: both execute, count unchanged, no overflow;
  - when empty: the pop is ignored, the push executes, and count becomes 1.
- Overflow occurs when valid_i=1, full_o=1 and pop_i=0:
  - the incoming frame is dropped and stored entries are untouched;
  - overflow_o is set on the next edge.
- clear_ovf_i clears overflow_o. If a new overflow occurs in the same cycle, setting wins.
- flush_i has priority over push, pop and overflow:
  - pointers and count return to 0, and a concurrent valid_i frame is dropped;
  - overflow_o is cleared and is not set by that dropped frame;
  - array contents need not be cleared.
- count_o is a registered counter, updated +1, −1 or 0 per cycle. It must always equal write pointer − read pointer.
- empty_o = (count_o==0), full_o = (count_o==DEPTH), threshold_o = (count_o ≥ THRESHOLD); all are derived from registered state.
- data_o and parity_err_o are the head entry gated by !empty_o.

## Timing
- Reset (rst_ni low, asynchronous) sets:
  - pointers, count_o and overflow_o to 0;
  - empty_o=1, full_o=0, threshold_o=0;
  - data_o=0, parity_err_o=0.
- Reset release is synchronised externally; the block needs none.
- Push latency: a frame strobed at edge N appears on data_o, with flags updated, after edge N, i.e. one cycle later.
- Pop: after the edge on which pop_i=1 is sampled, data_o shows the next entry, or 0 if the FIFO is now empty.
- Back-to-back valid_i on consecutive cycles must be accepted up to DEPTH entries with no bubbles.
- Back-to-back pops on consecutive cycles must drain one entry per cycle.
- All outputs are registered or derived combinationally from registers only. There is no input-to-output combinational path.

## Structure
- The shared package uart_pkg holds:
  - MAX_FRAME_SIZE (=11) and MIN_FRAME_SIZE (=8);
  - register index constants (SR, CR, RXDR, TXDR);
  - a packed struct rx_entry_t {logic parity_err; logic[MAX_FRAME_SIZE-1:0] frame;}.
- WIDTH defaults to uart_pkg::MAX_FRAME_SIZE.
- One sub-module is natural: fifo_mem, a DEPTH×(WIDTH+1) register array with synchronous write and asynchronous read.
  - It has no reset on storage.
  - All pointer, count and flag logic stays in uart_rx_fifo.
- Add an assertion that DEPTH is a power of two and that 1 ≤ THRESHOLD ≤ DEPTH.

## Test plan
- Reset then idle:
  - Stimulus: assert rst_ni mid-cycle, then release.
  - Required: empty_o=1, count_o=0, data_o=0, overflow_o=0 immediately (asynchronous).
- Single frame:
  - Stimulus: valid_i pulse with frame_i=11'h155, parity_err_i=1.
  - Required: next cycle data_o=11'h155, parity_err_o=1, count_o=1; after pop_i, empty_o=1 and data_o=0.
- Fill and overflow (DEPTH=8):
  - Stimulus: push 0x01..0x08, then push 0x09 with no pop.
  - Required: full_o=1, overflow_o=1, count_o=8; popping yields 0x01..0x08 in order, and 0x09 is never seen.
- Simultaneous push and pop:
  - When full: push 0x20 with pop → count stays 8, no overflow, 0x20 becomes the last entry.
  - When empty: push 0x30 with pop → count_o=1, data_o=0x30.
- Threshold, wrap and clear:
  - Stimulus: 20 interleaved push/pop cycles crossing the pointer wrap.
  - Required: FIFO ordering holds; threshold_o toggles exactly at count 4; clear_ovf_i concurrent with a new overflow leaves overflow_o=1.
- Flush:
  - Stimulus: with 5 entries and overflow_o=1, assert flush_i together with valid_i.
  - Required: next cycle count_o=0, empty_o=1, overflow_o=0, and the concurrent frame is discarded.
